// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, FSM states and byte-enable patterns for the memory stage
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [3:0] BE_NONE  = 4'b0000;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_LO    = 4'b0011;
    localparam logic [3:0] BE_HI    = 4'b1100;
    localparam logic [3:0] BE_ALL   = 4'b1111;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-enable/data replication and load extract/extend
module mem_lane_align import mem_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = rdata >> {addr_lo, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Steer stores onto lanes and pick/extend the loaded byte or halfword
    always_comb begin
        be        = (funct3[1:0] == F3_W[1:0]) ? BE_ALL :
                    (funct3[1:0] == F3_H[1:0]) ? (addr_lo[1] ? BE_HI : BE_LO) :
                    BE_BYTE0 << addr_lo;
        wdata     = (funct3[1:0] == F3_W[1:0]) ? st_data :
                    (funct3[1:0] == F3_H[1:0]) ? {2{st_data[15:0]}} :
                    {4{st_data[7:0]}};
        load_data = (funct3 == F3_B)  ? {{24{byte_sel[7]}}, byte_sel} :
                    (funct3 == F3_H)  ? {{16{half_sel[15]}}, half_sel} :
                    (funct3 == F3_BU) ? {24'b0, byte_sel} :
                    (funct3 == F3_HU) ? {16'b0, half_sel} :
                    rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with req/ack data bus, timeout and lane alignment.
// Optional macro MEM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses with wb_err.
module mem_stage import mem_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        wb_err
);
    state_t             state, state_nxt;
    logic [TMR_W-1:0]   cnt;
    logic [2:0]         op_f3;
    logic [1:0]         op_lo;
    logic [31:0]        op_wdata;
    logic [4:0]         op_rd;
    logic               op_rw;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [31:0]        load_data;
    logic               is_mem, ld_ok, st_ok, misalign, accept, go_busy, busy, timeout;

    assign is_mem  = ex_mem_read | ex_mem_write;
    assign ld_ok   = ex_mem_read & ~ex_mem_write &
                     (ex_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign st_ok   = ex_mem_write & ~ex_mem_read & (ex_funct3 inside {F3_B, F3_H, F3_W});
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((ex_funct3[1:0] == F3_H[1:0]) & ex_alu_result[0]) |
                      ((ex_funct3 == F3_W) & (|ex_alu_result[1:0]));
`else
    assign misalign = 1'b0;
`endif
    assign busy    = (state == ST_BUSY);
    assign accept  = ~busy & ex_valid;
    assign go_busy = accept & (ld_ok | st_ok) & ~misalign;
    // Counter starts at 0 on the first BUSY cycle, so this fires on BUSY cycle TIMEOUT_CYCLES
    assign timeout = (cnt == TMR_W'(TIMEOUT_CYCLES - 1));

    assign ex_ready   = ~busy;
    assign dmem_be    = dmem_req ? be : BE_NONE;
    assign dmem_wdata = dmem_req ? wdata : 32'b0;

    mem_lane_align u_align (
        .funct3    (op_f3),
        .addr_lo   (op_lo),
        .st_data   (op_wdata),
        .rdata     (dmem_rdata),
        .be        (be),
        .wdata     (wdata),
        .load_data (load_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: enter BUSY on a legal access, leave on ack or timeout
    always_comb begin
        state_nxt = state;
        state_nxt = busy ? ((dmem_ack | timeout) ? ST_IDLE : ST_BUSY)
                         : (go_busy ? ST_BUSY : ST_IDLE);
    end

    // Bus request, latched operation, timeout counter and writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'b0;
            op_f3        <= 3'b0;
            op_lo        <= 2'b0;
            op_wdata     <= 32'b0;
            op_rd        <= 5'b0;
            op_rw        <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'b0;
            wb_err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
            if (go_busy) begin
                cnt       <= '0;
                dmem_req  <= 1'b1;
                dmem_we   <= ex_mem_write;
                dmem_addr <= {ex_alu_result[31:2], 2'b00};
                op_f3     <= ex_funct3;
                op_lo     <= ex_alu_result[1:0];
                op_wdata  <= ex_store_data;
                op_rd     <= ex_rd;
                op_rw     <= ex_reg_write;
            end else if (accept) begin
                // Non-memory op passes through; any rejected memory op reports an error
                wb_valid     <= 1'b1;
                wb_rd        <= ex_rd;
                wb_err       <= is_mem;
                wb_reg_write <= ex_reg_write & ~is_mem;
                wb_data      <= is_mem ? 32'b0 : ex_alu_result;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
                if (dmem_ack | timeout) begin
                    dmem_req     <= 1'b0;
                    dmem_we      <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= op_rd;
                    wb_err       <= ~dmem_ack;
                    wb_reg_write <= dmem_ack & ~dmem_we & op_rw;
                    wb_data      <= (dmem_ack & ~dmem_we) ? load_data : 32'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, wb_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .wb_err        (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op for a single rising edge, return at the following negedge
    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        ex_valid      = 1'b1;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_funct3     = f3;
        ex_alu_result = a;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
        @(negedge clk);
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        dmem_ack   = 1'b1;
        dmem_rdata = d;
        @(negedge clk);
        dmem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = 3'b0; ex_alu_result = 32'b0; ex_store_data = 32'b0;
        ex_rd = 5'b0; ex_reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_be", dmem_be, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU pass-through
        issue(0, 0, 3'b000, 32'h0000_1234, 0, 5'd5, 1);
        chk("alu_valid", wb_valid, 1);
        chk("alu_data", wb_data, 32'h1234);
        chk("alu_rd", wb_rd, 5);
        chk("alu_rw", wb_reg_write, 1);
        chk("alu_err", wb_err, 0);
        chk("alu_req", dmem_req, 0);
        @(negedge clk);
        chk("alu_pulse", wb_valid, 0);

        // LB at 0x103, ack on third BUSY cycle
        issue(1, 0, 3'b000, 32'h0000_0103, 0, 5'd9, 1);
        chk("lb_req", dmem_req, 1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we", dmem_we, 0);
        chk("lb_ready", ex_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("lb_hold_req", dmem_req, 1);
        chk("lb_hold_valid", wb_valid, 0);
        ack(32'h80FF_0000);
        chk("lb_valid", wb_valid, 1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_rd", wb_rd, 9);
        chk("lb_rw", wb_reg_write, 1);
        chk("lb_req_drop", dmem_req, 0);
        chk("lb_ready_back", ex_ready, 1);

        // LHU at 0x202
        issue(1, 0, 3'b101, 32'h0000_0202, 0, 5'd7, 1);
        chk("lhu_addr", dmem_addr, 32'h200);
        ack(32'hABCD_0000);
        chk("lhu_data", wb_data, 32'h0000_ABCD);
        chk("lhu_rd", wb_rd, 7);

        // LH at 0x100, negative halfword
        issue(1, 0, 3'b001, 32'h0000_0100, 0, 5'd3, 1);
        ack(32'h0000_8001);
        chk("lh_data", wb_data, 32'hFFFF_8001);

        // LBU at 0x001
        issue(1, 0, 3'b100, 32'h0000_0001, 0, 5'd4, 1);
        ack(32'h0000_F000);
        chk("lbu_data", wb_data, 32'h0000_00F0);

        // SB at 0x101
        issue(0, 1, 3'b000, 32'h0000_0101, 32'h0000_005A, 5'd2, 1);
        chk("sb_we", dmem_we, 1);
        chk("sb_be", dmem_be, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        chk("sb_addr", dmem_addr, 32'h100);
        ack(32'h0);
        chk("sb_valid", wb_valid, 1);
        chk("sb_rw", wb_reg_write, 0);
        chk("sb_err", wb_err, 0);

        // SH at 0x102
        issue(0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 5'd2, 1);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        ack(32'h0);

        // SW at 0x010
        issue(0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd2, 1);
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        ack(32'h0);

        // Timeout: no ack for 16 BUSY cycles
        issue(1, 0, 3'b010, 32'h0000_0300, 0, 5'd6, 1);
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("to_req_c16", dmem_req, 1);
        @(negedge clk);
        chk("to_req_drop", dmem_req, 0);
        chk("to_valid", wb_valid, 1);
        chk("to_err", wb_err, 1);
        chk("to_rw", wb_reg_write, 0);

        // Ack exactly on cycle 16 wins over timeout
        issue(1, 0, 3'b010, 32'h0000_0300, 0, 5'd6, 1);
        for (int i = 0; i < 15; i++) @(negedge clk);
        ack(32'hCAFE_F00D);
        chk("ack16_valid", wb_valid, 1);
        chk("ack16_err", wb_err, 0);
        chk("ack16_data", wb_data, 32'hCAFE_F00D);

        // Illegal funct3 load
        issue(1, 0, 3'b011, 32'h0000_0400, 0, 5'd8, 1);
        chk("ill_valid", wb_valid, 1);
        chk("ill_err", wb_err, 1);
        chk("ill_rw", wb_reg_write, 0);
        chk("ill_req", dmem_req, 0);

        // Read and write both high
        issue(1, 1, 3'b000, 32'h0000_0400, 0, 5'd8, 1);
        chk("rw_both_err", wb_err, 1);
        chk("rw_both_req", dmem_req, 0);

        // Reset while BUSY
        issue(1, 0, 3'b010, 32'h0000_0400, 0, 5'd1, 1);
        chk("rb_req", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_req_drop", dmem_req, 0);
        chk("rb_ready", ex_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        // Ack while IDLE is ignored
        ack(32'h1111_1111);
        chk("rb_no_wb", wb_valid, 0);
        chk("idle_ack_req", dmem_req, 0);
        @(negedge clk);
        chk("rb_no_wb2", wb_valid, 0);

        // LW at 0x102
        issue(1, 0, 3'b010, 32'h0000_0102, 0, 5'd10, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", dmem_req, 0);
        chk("mis_valid", wb_valid, 1);
        chk("mis_err", wb_err, 1);
        chk("mis_rw", wb_reg_write, 0);
`else
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_req", dmem_req, 1);
        ack(32'h1122_3344);
        chk("mis_data", wb_data, 32'h1122_3344);
        chk("mis_err", wb_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes ALU result (address or data) and rs2 store data.
- Drives a req/ack data-memory bus, performs byte-lane steering and load sign/zero extension.
- Presents a registered result to writeback; stalls execute while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, cycles in BUSY without dmem_ack before the access aborts with a bus error (minimum 2).
TMR_W, 5, width of the timeout counter; must satisfy 2**TMR_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
ex_valid  in  1  execute-stage output valid.
ex_ready  out  1  stage can accept; high only in IDLE.
ex_mem_read  in  1  load op.
ex_mem_write  in  1  store op.
ex_funct3  in  3  access size/sign (RV32I encoding).
ex_alu_result  in  32  address for mem ops; result otherwise.
ex_store_data  in  32  rs2 value for stores.
ex_rd  in  5  destination register.
ex_reg_write  in  1  writeback enable.
dmem_req  out  1  request, held until ack or timeout.
dmem_we  out  1  1 = store.
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
dmem_be  out  4  byte enables.
dmem_wdata  out  32  lane-replicated store data.
dmem_ack  in  1  one-cycle completion pulse.
dmem_rdata  in  32  read word, valid with dmem_ack.
wb_valid  out  1  one-cycle result pulse.
wb_rd  out  5  destination register.
wb_reg_write  out  1  writeback enable (forced 0 on error).
wb_data  out  32  result / extended load data.
wb_err  out  1  access aborted (timeout, illegal funct3, or misaligned).

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except ex_ready=1; timeout counter 0. Reset mid-access drops dmem_req immediately; no wb_valid is produced for the lost access.
- States: IDLE, BUSY.
- IDLE: ex_ready=1. Accept when ex_valid=1.
  - Non-mem op: next cycle wb_valid=1, wb_data=ex_alu_result, wb_rd/wb_reg_write copied; stay IDLE. Latency 1.
  - Mem op with legal funct3: latch op, funct3, addr[1:0], rd, reg_write; go BUSY. dmem_req=1 from the next cycle.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000, 001, 010.
  - Illegal funct3: no bus request; next cycle wb_valid=1, wb_err=1, wb_reg_write=0.
  - ex_mem_read and ex_mem_write both high: treated as illegal.
- BUSY: ex_ready=0; dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata held stable.
  - Counter increments each BUSY cycle.
  - dmem_ack=1: drop req the same edge. Next cycle wb_valid=1 with extracted data (loads) or wb_reg_write=0 (stores). Return IDLE.
  - Counter reaching TIMEOUT_CYCLES without ack: drop req; next cycle wb_valid=1, wb_err=1, wb_reg_write=0; return IDLE.
  - Ack arriving on the same cycle as timeout: ack wins.
  - dmem_ack while IDLE: ignored.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{b[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{b[15:0]}}.
  - SW: be=1111.
- Loads: byte/half selected by latched addr[1:0], then sign- or zero-extended per funct3.
- Back-to-back: the next op is accepted the cycle after wb_valid (IDLE re-entered).

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no bus request. Next cycle wb_valid=1, wb_err=1, wb_reg_write=0.
- Undefined: no check. Halfword uses addr[1] only; word ignores addr[1:0].

Decomposition:
- Shared package mem_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding (ST_IDLE, ST_BUSY).
  - Byte-enable constants.
- Sub-module mem_lane_align (combinational):
  - Store path: be/wdata generation.
  - Load path: extract and extend.
- FSM, counter and registers stay in mem_stage.

Test Plan:
- ALU pass-through: ex_alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; dmem_req never asserts.
- LB at addr 0x103, ack after 3 cycles with rdata=0x80FF_0000 -> dmem_addr=0x100, ex_ready=0 while busy; wb_data=0xFFFF_FF80 one cycle after ack.
- LHU at 0x202, rdata=0xABCD_0000 -> wb_data=0x0000_ABCD.
- SB at 0x101, store_data=0x0000_005A -> dmem_we=1, be=0010, wdata=0x5A5A_5A5A, wb_reg_write=0.
- No ack for 16 BUSY cycles -> dmem_req drops; wb_valid=1, wb_err=1, wb_reg_write=0. Repeat with ack on cycle 16 -> normal completion.
- rst_n pulsed low while BUSY -> dmem_req=0 immediately; no wb_valid after release.
- LW at 0x102 -> with MEM_MISALIGN_TRAP_EN, no dmem_req and wb_err=1; without it, dmem_addr=0x100 and normal completion.
